// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared system bus.
// Master 0 (CPU) and master 1 (DMA/debug) each own the bus for one
// transaction per grant. A per-transaction ack timeout aborts a hung
// access, acks the master with zero data and raises a one-cycle bus_err.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | bus unowned, arbitrate pending requests
// ST_OWN0  | master 0 owns the bus, forwarding until ack/timeout/drop
// ST_OWN1  | master 1 owns the bus, forwarding until ack/timeout/drop
module bus_arbiter #(
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [21:0] m0_addr,
  input  logic [31:0] m0_dout,
  output logic [31:0] m0_din,
  output logic        m0_ack,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [21:0] m1_addr,
  input  logic [31:0] m1_dout,
  output logic [31:0] m1_din,
  output logic        m1_ack,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [21:0] bus_addr,
  output logic [31:0] bus_dout,
  input  logic [31:0] bus_din,
  input  logic        bus_ack,
  output logic [1:0]  grant,
  output logic        bus_err,
  output logic        err_master,
  output logic [21:0] err_addr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  // A zero setting disables the timeout; TMO_LAST is then never used.
  localparam bit         TMO_EN   = (timeout_cycles != 32'd0);
  localparam logic [15:0] TMO_LAST = 16'(timeout_cycles - 32'd1);

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_master_q, err_master_d;
  logic [21:0] err_addr_q, err_addr_d;

  logic        own0, own1, owned;
  logic        sel_stb, sel_we;
  logic [21:0] sel_addr;
  logic [31:0] sel_dout;
  logic        done, timeout;

  // Owner decode and selection of the owning master's request lines
  always_comb begin
    own0     = (state_q == ST_OWN0);
    own1     = (state_q == ST_OWN1);
    owned    = own0 | own1;
    sel_stb  = own1 ? m1_stb  : (own0 & m0_stb);
    sel_we   = own1 ? m1_we   : (own0 & m0_we);
    sel_addr = own1 ? m1_addr : (own0 ? m0_addr : 22'd0);
    sel_dout = own1 ? m1_dout : (own0 ? m0_dout : 32'd0);
    done     = owned & sel_stb & bus_ack;
    // A slave ack in the last allowed cycle wins over the timeout.
    timeout  = owned & sel_stb & ~bus_ack & TMO_EN & (cnt_q == TMO_LAST);
  end

  // Bus-side and master-side outputs, purely from state and live inputs
  always_comb begin
    bus_stb    = sel_stb & ~timeout;
    bus_we     = sel_we;
    bus_addr   = sel_addr;
    bus_dout   = sel_dout;
    m0_ack     = own0 & (done | timeout);
    m1_ack     = own1 & (done | timeout);
    m0_din     = (own0 & ~timeout) ? bus_din : 32'd0;
    m1_din     = (own1 & ~timeout) ? bus_din : 32'd0;
    grant      = {own1, own0};
    bus_err    = timeout;
    err_master = err_master_q;
    err_addr   = err_addr_q;
  end

  // Arbitration, completion, timeout and protocol-drop next-state logic
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    err_master_d = err_master_q;
    err_addr_d   = err_addr_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 16'd0;
        if (m0_stb && m1_stb) begin
          state_d = last_q ? ST_OWN0 : ST_OWN1;
        end else if (m0_stb) begin
          state_d = ST_OWN0;
        end else if (m1_stb) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!sel_stb) begin
          // Owner abandoned the request: release without touching fairness.
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else if (done || timeout) begin
          state_d = ST_IDLE;
          last_d  = own1;
          cnt_d   = 16'd0;
          if (timeout) begin
            err_master_d = own1;
            err_addr_d   = sel_addr;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // State registers with synchronous reset; master 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b1;
      cnt_q        <= 16'd0;
      err_master_q <= 1'b0;
      err_addr_q   <= 22'd0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      err_master_q <= err_master_d;
      err_addr_q   <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a transaction-level model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_bus_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_stb, m0_we, m1_stb, m1_we;
  logic [21:0] m0_addr, m1_addr;
  logic [31:0] m0_dout, m1_dout;
  logic [31:0] m0_din, m1_din;
  logic        m0_ack, m1_ack;
  logic        bus_stb, bus_we;
  logic [21:0] bus_addr;
  logic [31:0] bus_dout;
  logic [31:0] bus_din;
  logic        bus_ack;
  logic [1:0]  grant;
  logic        bus_err, err_master;
  logic [21:0] err_addr;

  int tests_run = 0;
  int tests_failed = 0;

  bus_arbiter #(.timeout_cycles(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m0_din(m0_din), .m0_ack(m0_ack),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .m1_din(m1_din), .m1_ack(m1_ack),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_dout(bus_dout),
    .bus_din(bus_din), .bus_ack(bus_ack),
    .grant(grant), .bus_err(bus_err), .err_master(err_master), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slave: acks on the slave_lat-th cycle of a granted transaction (0 = never).
  int          slave_lat = 0;
  logic [31:0] slave_data = 32'h0;
  int          s_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (grant != 2'b00) s_cnt++;
    else s_cnt = 0;
    bus_ack = (slave_lat != 0) && (s_cnt == slave_lat);
    bus_din = slave_data;
  end

  // Reference model: who owns the bus, how long it has waited, who went last.
  int          m_owner = -1;
  int          m_cnt = 0;
  int          m_last = 1;
  bit          m_valid = 0;
  logic        m_errm = 1'b0;
  logic [21:0] m_erra = 22'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_owner = -1; m_cnt = 0; m_last = 1; m_errm = 0; m_erra = 0;
    end else if (m_valid) begin
      if (m_owner < 0) begin
        if (m0_stb && m1_stb) m_owner = 1 - m_last;
        else if (m0_stb) m_owner = 0;
        else if (m1_stb) m_owner = 1;
        m_cnt = 0;
      end else begin
        logic        stbx;
        logic [21:0] addrx;
        stbx  = (m_owner == 0) ? m0_stb : m1_stb;
        addrx = (m_owner == 0) ? m0_addr : m1_addr;
        if (!stbx) begin
          m_owner = -1;
        end else if (bus_ack) begin
          m_last = m_owner; m_owner = -1;
        end else if (TMO != 0 && m_cnt + 1 == TMO) begin
          m_errm = (m_owner == 1); m_erra = addrx;
          m_last = m_owner; m_owner = -1;
        end else begin
          m_cnt++;
        end
        if (m_owner < 0) m_cnt = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (m_valid) begin
      logic        stbx, wex, tmo, e_stb;
      logic [21:0] addrx;
      logic [31:0] doutx;
      logic [31:0] e_m0_din, e_m1_din;
      logic        e_m0_ack, e_m1_ack;
      logic [1:0]  e_grant;
      stbx = 0; wex = 0; addrx = 0; doutx = 0;
      if (m_owner == 0) begin stbx = m0_stb; wex = m0_we; addrx = m0_addr; doutx = m0_dout; end
      if (m_owner == 1) begin stbx = m1_stb; wex = m1_we; addrx = m1_addr; doutx = m1_dout; end
      tmo      = (m_owner >= 0) && stbx && !bus_ack && (m_cnt + 1 == TMO);
      e_stb    = stbx && !tmo;
      e_m0_ack = (m_owner == 0) && stbx && (bus_ack || tmo);
      e_m1_ack = (m_owner == 1) && stbx && (bus_ack || tmo);
      e_m0_din = (m_owner == 0 && !tmo) ? bus_din : 32'h0;
      e_m1_din = (m_owner == 1 && !tmo) ? bus_din : 32'h0;
      e_grant  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      chk("cyc_bus", 64'({bus_stb, bus_we, bus_addr, bus_dout}), 64'({e_stb, wex, addrx, doutx}));
      chk("cyc_m0", 64'({m0_ack, m0_din}), 64'({e_m0_ack, e_m0_din}));
      chk("cyc_m1", 64'({m1_ack, m1_din}), 64'({e_m1_ack, e_m1_din}));
      chk("cyc_ctl", 64'({grant, bus_err, err_master, err_addr}), 64'({e_grant, tmo, m_errm, m_erra}));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_ack(input int idx, input int budget, output int n,
                          output logic [31:0] din, output logic err);
    bit got;
    n = 0; din = 32'h0; err = 1'b0; got = 0;
    while (!got && n < budget) begin
      @(negedge clk);
      n++;
      if ((idx == 0 && m0_ack) || (idx == 1 && m1_ack)) begin
        got = 1;
        din = (idx == 0) ? m0_din : m1_din;
        err = bus_err;
      end
    end
    if (!got) begin
      tests_run++;
      tests_failed++;
      $display("FAIL ack_wait_m%0d: no ack within %0d cycles", idx, budget);
    end
  endtask

  int          n;
  logic [31:0] din;
  logic        err;
  int          seq[$];

  initial begin
    rst = 1'b1;
    m0_stb = 0; m0_we = 0; m0_addr = 0; m0_dout = 0;
    m1_stb = 0; m1_we = 0; m1_addr = 0; m1_dout = 0;
    bus_ack = 0; bus_din = 0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_stb", 64'({bus_stb, m0_ack, m1_ack}), 64'h0);
    step();

    // Single read by master 0
    slave_lat = 3; slave_data = 32'hDEADBEEF;
    m0_stb = 1; m0_we = 0; m0_addr = 22'h3FFFF0;
    @(negedge clk);
    chk("t1_lat_idle", 64'(bus_stb), 64'h0);
    @(negedge clk);
    chk("t1_stb", 64'({bus_stb, grant}), 64'({1'b1, 2'b01}));
    wait_ack(0, 20, n, din, err);
    chk("t1_ack_cyc", 64'(n), 64'd2);
    chk("t1_din", 64'(din), 64'hDEADBEEF);
    step(); m0_stb = 0;
    @(negedge clk);
    chk("t1_after", 64'({grant, m0_ack}), 64'h0);

    // Simultaneous first request after reset: m0 first, then m1 write
    do_reset();
    slave_lat = 1; slave_data = 32'h0BADF00D;
    m0_stb = 1; m0_we = 0; m0_addr = 22'h000010;
    m1_stb = 1; m1_we = 1; m1_addr = 22'h000020; m1_dout = 32'h12345678;
    @(negedge clk);
    chk("t2_c0", 64'(grant), 64'h0);
    @(negedge clk);
    chk("t2_m0", 64'({grant, m0_ack}), 64'({2'b01, 1'b1}));
    step(); m0_stb = 0;
    @(negedge clk);
    chk("t2_gap", 64'(grant), 64'h0);
    @(negedge clk);
    chk("t2_m1", 64'({grant, bus_we, bus_dout, m1_ack}), 64'({2'b10, 1'b1, 32'h12345678, 1'b1}));
    step(); m1_stb = 0; m1_we = 0;

    // Continuous contention, 8 transactions
    slave_lat = 2; slave_data = 32'h00C0FFEE;
    m0_stb = 1; m0_addr = 22'h000100; m1_stb = 1; m1_addr = 22'h000200;
    n = 0;
    while (seq.size() < 8 && n < 100) begin
      @(negedge clk);
      n++;
      if (m0_ack) seq.push_back(0);
      if (m1_ack) seq.push_back(1);
    end
    step(); m0_stb = 0; m1_stb = 0;
    chk("t3_count", 64'(seq.size()), 64'd8);
    for (int i = 0; i < seq.size(); i++) chk("t3_rr", 64'(seq[i]), 64'(i % 2));

    // Timeout on master 1
    step();
    slave_lat = 0; slave_data = 32'h55AA55AA;
    m1_stb = 1; m1_we = 0; m1_addr = 22'h2AAAAA;
    wait_ack(1, 40, n, din, err);
    chk("t4_ack_cyc", 64'(n), 64'd17);
    chk("t4_din_err", 64'({din, err, bus_stb}), 64'({32'h0, 1'b1, 1'b0}));
    step(); m1_stb = 0;
    @(negedge clk);
    chk("t4_latch", 64'({bus_err, err_master, err_addr}), 64'({1'b0, 1'b1, 22'h2AAAAA}));

    // Ack in the same cycle the timeout would fire
    step();
    slave_lat = 16; slave_data = 32'hCAFEF00D;
    m0_stb = 1; m0_addr = 22'h000123;
    wait_ack(0, 40, n, din, err);
    chk("t5_ack_cyc", 64'(n), 64'd17);
    chk("t5_din_err", 64'({din, err}), 64'({32'hCAFEF00D, 1'b0}));
    step(); m0_stb = 0;
    @(negedge clk);
    chk("t5_err_kept", 64'({err_master, err_addr}), 64'({1'b1, 22'h2AAAAA}));

    // Reset mid-transaction, then owner drops its request
    step();
    slave_lat = 0;
    m0_stb = 1; m0_addr = 22'h000777;
    @(negedge clk);
    @(negedge clk);
    chk("t6_own", 64'(grant), 64'h1);
    step(); rst = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_rst", 64'({bus_stb, grant, m0_ack, err_master}), 64'h0);
    step(); rst = 0;
    @(negedge clk);
    chk("t6_rel_idle", 64'(bus_stb), 64'h0);
    @(negedge clk);
    chk("t6_regrant", 64'({bus_stb, grant}), 64'({1'b1, 2'b01}));
    step(); m0_stb = 0;
    @(negedge clk);
    chk("t6_drop", 64'({m0_ack, bus_err}), 64'h0);
    @(negedge clk);
    chk("t6_drop_idle", 64'(grant), 64'h0);

    // Dropped transaction must not move fairness: m0 still wins the tie
    step();
    slave_lat = 1;
    m0_stb = 1; m1_stb = 1;
    @(negedge clk);
    @(negedge clk);
    chk("t7_tie", 64'({grant, m0_ack}), 64'({2'b01, 1'b1}));
    step(); m0_stb = 0;
    wait_ack(1, 10, n, din, err);
    step(); m1_stb = 0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter that shares the single system bus between master 0 (the CPU) and master 1 (a second bus master, e.g. a DMA or debug engine).
- Sits between the masters and the existing address decode / data and ack multiplexing; slaves are unchanged.
- Round-robin grant, one transaction per grant, and a per-transaction ack timeout.
- A timeout raises an error pulse suitable for a system control and status error-signal input.

Parameters:
timeout_cycles, 1024, cycles without bus_ack before the transaction is aborted; 0 disables the timeout; maximum 65535 (16-bit counter)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
m0_stb  in  1  master 0 request, held until m0_ack
m0_we  in  1  master 0 write enable
m0_addr  in  22  master 0 word address [23:2]
m0_dout  in  32  master 0 write data
m0_din  out  32  read data to master 0
m0_ack  out  1  transaction done, master 0
m1_stb  in  1  master 1 request, held until m1_ack
m1_we  in  1  master 1 write enable
m1_addr  in  22  master 1 word address [23:2]
m1_dout  in  32  master 1 write data
m1_din  out  32  read data to master 1
m1_ack  out  1  transaction done, master 1
bus_stb  out  1  strobe to address decode
bus_we  out  1  write enable to slaves
bus_addr  out  22  word address [23:2] to decode and slaves
bus_dout  out  32  write data to slaves
bus_din  in  32  muxed read data from slaves
bus_ack  in  1  muxed ack from slaves
grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle
bus_err  out  1  one-cycle pulse on timeout
err_master  out  1  master that timed out, latched
err_addr  out  22  address that timed out, latched

Behaviour:
- Registered state: IDLE, OWN0, OWN1; last (last served master); 16-bit wait counter; err_master/err_addr registers.
- Reset (synchronous, rst=1 at an edge) sets:
  - state IDLE, last=1 (master 0 wins the first tie), counter 0;
  - err_master 0, err_addr 0, bus_err 0.
- Outputs are combinational from state, so after the reset edge: bus_stb=0, grant=00, m0_ack=m1_ack=0.
- IDLE, arbitration:
  - only m0_stb set -> OWN0;
  - only m1_stb set -> OWN1;
  - both set -> the master that is not `last`;
  - none set -> stay IDLE.
  - No bus outputs are driven in IDLE. Grant latency is 1 cycle from the request to bus_stb.
- OWNx, forwarding:
  - bus_stb=mx_stb, bus_we=mx_we, bus_addr=mx_addr, bus_dout=mx_dout;
  - mx_din=bus_din, mx_ack=bus_ack, grant one-hot x.
  - The non-owner sees din=0 and ack=0.
- When not owned: bus_we, bus_addr and bus_dout are forced to 0 (no spurious decode or write).
- OWNx, completion: bus_ack=1 in a cycle -> ack passed through that same cycle; next state IDLE, last=x, counter cleared.
  - There is always one IDLE cycle between transactions, so the same master cannot re-trigger on a still-high stb.
- OWNx, timeout: timeout_cycles≠0 and counter==timeout_cycles-1 with no bus_ack. In that cycle:
  - mx_ack=1, mx_din=0, bus_stb=0;
  - bus_err=1 for this one cycle;
  - err_master<=x, err_addr<=mx_addr;
  - next state IDLE, last=x.
  - The counter increments each OWN cycle without ack.
- bus_ack and timeout in the same cycle: bus_ack wins, normal completion, no bus_err.
- Owner drops mx_stb before ack (protocol violation): return to IDLE next cycle, no ack, no error; `last` is unchanged.
- Fairness: with both masters continuously requesting, grants alternate 0,1,0,1; neither waits more than one foreign transaction plus 2 cycles.
- bus_ack received while in IDLE is ignored.
- rst asserted mid-transaction: IDLE at the next edge, no ack issued; the master must re-request.

Test Plan:
- Single read: m0_stb with addr 0x3FFFF0, no m1 request; slave acks 2 cycles after bus_stb with 0xDEADBEEF -> bus_stb 1 cycle after request; m0_ack high 1 cycle with m0_din=0xDEADBEEF; grant=01 during, 00 after.
- Simultaneous first request: m0_stb and m1_stb asserted together after reset -> m0 served first (grant=01), then one IDLE cycle, then grant=10; m1 write data 0x12345678 appears on bus_dout with bus_we=1.
- Continuous contention: both masters re-request immediately after every ack for 8 transactions -> grant sequence 01,10,01,10,...; no master is acked twice in a row.
- Timeout: timeout_cycles=16; m1 reads an address that is never acked -> m1_ack=1 with m1_din=0 on the 16th OWN cycle; bus_err pulse 1 cycle; err_master=1; err_addr equals the address.
- Ack and timeout in the same cycle: timeout_cycles=16 and slave acks on the 16th OWN cycle -> normal completion with slave data; bus_err=0.
- Reset mid-transaction: rst asserted while in OWN0 before ack -> bus_stb=0 and grant=00 after the edge; no m0_ack; after rst is released, m0 still requesting gets bus_stb 1 cycle later.
